// File: rtl/debug_breakpoint.sv
// Address-breakpoint / single-step unit: watches the GB bus and holds `halt`
// on a programmed access until a debounced resume releases it.
module debug_breakpoint #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned RESUME_LOCKOUT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr,
    input  logic        rd,
    input  logic        wr,
    input  logic        cs,
    input  logic [15:0] bp_addr,
    input  logic [15:0] bp_mask,
    input  logic [1:0]  bp_mode,
    input  logic [7:0]  bp_count,
    input  logic        step,
    input  logic        resume,
    output logic        halt,
    output logic [15:0] hit_addr,
    output logic        hit_wr,
    output logic [7:0]  hits
);

    localparam int unsigned AW = 16;
    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_HALTED  = 2'b01,
        ST_RELEASE = 2'b10
    } state_e;

    logic [SYNC_STAGES-1:0] rd_sync_q, wr_sync_q, cs_sync_q, res_sync_q;
    logic [AW-1:0]          addr_sync_q [SYNC_STAGES];

    state_e        state_q, state_d;
    logic [15:0]   lockout_q, lockout_d;
    logic [CW-1:0] hit_cnt_q, hit_cnt_d;
    logic          active_q, res_prev_q;
    logic          halt_q, halt_d;
    logic [AW-1:0] hit_addr_q, hit_addr_d;
    logic          hit_wr_q, hit_wr_d;
    logic [CW-1:0] hits_q, hits_d;

    logic          rd_s, wr_s, cs_s, res_s;
    logic [AW-1:0] addr_s;
    logic          active_c, start_c, is_wr_c, match_c, cnt_hit_c, fire_c, res_rise_c;
    logic [CW-1:0] bp_limit_c;

    // Strobes and address share the same synchronizer depth to stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_sync_q  <= '1;
            wr_sync_q  <= '1;
            cs_sync_q  <= '1;
            res_sync_q <= '0;
            for (int i = 0; i < int'(SYNC_STAGES); i++) addr_sync_q[i] <= '0;
        end else begin
            rd_sync_q  <= {rd_sync_q[SYNC_STAGES-2:0], rd};
            wr_sync_q  <= {wr_sync_q[SYNC_STAGES-2:0], wr};
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cs};
            res_sync_q <= {res_sync_q[SYNC_STAGES-2:0], resume};
            addr_sync_q[0] <= addr;
            for (int i = 1; i < int'(SYNC_STAGES); i++) addr_sync_q[i] <= addr_sync_q[i-1];
        end
    end

    assign rd_s   = rd_sync_q[SYNC_STAGES-1];
    assign wr_s   = wr_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign res_s  = res_sync_q[SYNC_STAGES-1];
    assign addr_s = addr_sync_q[SYNC_STAGES-1];

    assign active_c   = ~cs_s & (~rd_s | ~wr_s);
    assign start_c    = active_c & ~active_q;
    assign is_wr_c    = ~wr_s;
    assign res_rise_c = res_s & ~res_prev_q;
    assign match_c    = (((addr_s ^ bp_addr) & bp_mask) == '0)
                      & (is_wr_c ? bp_mode[1] : bp_mode[0]);
    assign bp_limit_c = (bp_count == '0) ? CW'(1) : bp_count;
    assign cnt_hit_c  = ((9'(hit_cnt_q) + 9'd1) >= 9'(bp_limit_c));
    assign fire_c     = (state_q == ST_RUN) & start_c & (step | (match_c & cnt_hit_c));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            lockout_q  <= '0;
            hit_cnt_q  <= '0;
            active_q   <= 1'b0;
            res_prev_q <= 1'b0;
            halt_q     <= 1'b0;
            hit_addr_q <= '0;
            hit_wr_q   <= 1'b0;
            hits_q     <= '0;
        end else begin
            state_q    <= state_d;
            lockout_q  <= lockout_d;
            hit_cnt_q  <= hit_cnt_d;
            active_q   <= active_c;
            res_prev_q <= res_s;
            halt_q     <= halt_d;
            hit_addr_q <= hit_addr_d;
            hit_wr_q   <= hit_wr_d;
            hits_q     <= hits_d;
        end
    end

    // Next state, lockout and match counter; only RUN evaluates accesses.
    always_comb begin
        state_d   = state_q;
        lockout_d = lockout_q;
        hit_cnt_d = hit_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (bp_mode == 2'b00) begin
                    hit_cnt_d = '0;
                end else if (!step && start_c && match_c) begin
                    hit_cnt_d = cnt_hit_c ? '0 : hit_cnt_q + CW'(1);
                end
                if (fire_c) state_d = ST_HALTED;
            end
            ST_HALTED: begin
                if (res_rise_c) begin
                    state_d   = ST_RELEASE;
                    lockout_d = 16'(RESUME_LOCKOUT);
                end
            end
            ST_RELEASE: begin
                if (lockout_q != '0) begin
                    lockout_d = lockout_q - 16'd1;
                end else if (!active_c) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        halt_d     = (state_d == ST_HALTED);
        hit_addr_d = hit_addr_q;
        hit_wr_d   = hit_wr_q;
        hits_d     = hits_q;
        if (fire_c) begin
            hit_addr_d = addr_s;
            hit_wr_d   = is_wr_c;
            hits_d     = (hits_q == '1) ? hits_q : hits_q + CW'(1);
        end
    end

    assign halt     = halt_q;
    assign hit_addr = hit_addr_q;
    assign hit_wr   = hit_wr_q;
    assign hits     = hits_q;

endmodule

// File: tb/tb_debug_breakpoint.sv
// Directed bench for debug_breakpoint: breakpoint match, count, single-step,
// resume debounce, asynchronous reset and saturation.
module tb_debug_breakpoint;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] addr = '0;
    logic        rd = 1'b1, wr = 1'b1, cs = 1'b1;
    logic [15:0] bp_addr = '0, bp_mask = '0;
    logic [1:0]  bp_mode = '0;
    logic [7:0]  bp_count = '0;
    logic        step = 1'b0, resume = 1'b0;
    logic        halt, hit_wr;
    logic [15:0] hit_addr;
    logic [7:0]  hits;

    int nvec = 0;
    int nerr = 0;

    debug_breakpoint #(.SYNC_STAGES(2), .RESUME_LOCKOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .rd(rd), .wr(wr), .cs(cs),
        .bp_addr(bp_addr), .bp_mask(bp_mask), .bp_mode(bp_mode), .bp_count(bp_count),
        .step(step), .resume(resume), .halt(halt), .hit_addr(hit_addr),
        .hit_wr(hit_wr), .hits(hits)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic access(input logic [15:0] a, input logic do_rd, input logic do_wr, input int hold);
        addr = a; cs = 1'b0; rd = ~do_rd; wr = ~do_wr;
        tick(hold);
        cs = 1'b1; rd = 1'b1; wr = 1'b1;
        tick(8);
    endtask

    task automatic pulse_resume();
        resume = 1'b1; tick(2); resume = 1'b0; tick(26);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(2);
    endtask

    task automatic config_bp(input logic [15:0] a, input logic [15:0] m, input logic [1:0] md,
                             input logic [7:0] c, input logic s);
        bp_addr = a; bp_mask = m; bp_mode = md; bp_count = c; step = s;
    endtask

    task automatic test_reset();
        do_reset();
        nvec++; if (halt !== 1'b0) begin $display("FAIL rst_halt: got %b want 0", halt); nerr++; end
        nvec++; if (hit_addr !== 16'h0000) begin $display("FAIL rst_hit_addr: got %h want 0000", hit_addr); nerr++; end
        nvec++; if (hit_wr !== 1'b0) begin $display("FAIL rst_hit_wr: got %b want 0", hit_wr); nerr++; end
        nvec++; if (hits !== 8'h00) begin $display("FAIL rst_hits: got %h want 00", hits); nerr++; end
    endtask

    task automatic test_write_bp();
        do_reset();
        config_bp(16'hFF40, 16'hFFFF, 2'b10, 8'd1, 1'b0);
        access(16'hFF40, 1'b1, 1'b0, 6);
        nvec++; if (halt !== 1'b0) begin $display("FAIL wbp_read_nohalt: got %b want 0", halt); nerr++; end
        access(16'hFF40, 1'b0, 1'b1, 6);
        nvec++; if (halt !== 1'b1) begin $display("FAIL wbp_halt: got %b want 1", halt); nerr++; end
        nvec++; if (hit_addr !== 16'hFF40) begin $display("FAIL wbp_addr: got %h want ff40", hit_addr); nerr++; end
        nvec++; if (hit_wr !== 1'b1) begin $display("FAIL wbp_wr: got %b want 1", hit_wr); nerr++; end
        nvec++; if (hits !== 8'd1) begin $display("FAIL wbp_hits: got %0d want 1", hits); nerr++; end
        pulse_resume();
        nvec++; if (halt !== 1'b0) begin $display("FAIL wbp_resumed: got %b want 0", halt); nerr++; end
    endtask

    task automatic test_mask_count();
        logic [15:0] seq [5];
        seq[0] = 16'hC012; seq[1] = 16'hD000; seq[2] = 16'hC0FF; seq[3] = 16'hC100; seq[4] = 16'hC001;
        do_reset();
        config_bp(16'hC000, 16'hFF00, 2'b01, 8'd3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            access(seq[i], 1'b1, 1'b0, 6);
            nvec++; if (halt !== 1'b0) begin $display("FAIL cnt_nohalt_%0d: got %b want 0", i, halt); nerr++; end
        end
        access(seq[4], 1'b1, 1'b0, 6);
        nvec++; if (halt !== 1'b1) begin $display("FAIL cnt_halt: got %b want 1", halt); nerr++; end
        nvec++; if (hit_addr !== 16'hC001) begin $display("FAIL cnt_addr: got %h want c001", hit_addr); nerr++; end
        nvec++; if (hit_wr !== 1'b0) begin $display("FAIL cnt_wr: got %b want 0", hit_wr); nerr++; end
        pulse_resume();
    endtask

    task automatic test_step();
        do_reset();
        config_bp(16'h0000, 16'h0000, 2'b00, 8'd1, 1'b1);
        addr = 16'h0150; cs = 1'b0; rd = 1'b0;
        tick(8);
        nvec++; if (halt !== 1'b1) begin $display("FAIL step_held_halt: got %b want 1", halt); nerr++; end
        resume = 1'b1; tick(2); resume = 1'b0;
        tick(40);
        nvec++; if (halt !== 1'b0) begin $display("FAIL step_held_release: got %b want 0", halt); nerr++; end
        cs = 1'b1; rd = 1'b1;
        tick(30);
        nvec++; if (halt !== 1'b0) begin $display("FAIL step_no_retrigger: got %b want 0", halt); nerr++; end
        nvec++; if (hits !== 8'd1) begin $display("FAIL step_hits1: got %0d want 1", hits); nerr++; end
        for (int i = 0; i < 2; i++) begin
            access(16'h0151 + 16'(i), 1'b1, 1'b0, 6);
            nvec++; if (halt !== 1'b1) begin $display("FAIL step_halt_%0d: got %b want 1", i, halt); nerr++; end
            pulse_resume();
        end
        nvec++; if (hits !== 8'd3) begin $display("FAIL step_hits3: got %0d want 3", hits); nerr++; end
    endtask

    task automatic test_bounce();
        do_reset();
        config_bp(16'h0000, 16'h0000, 2'b11, 8'd1, 1'b0);
        access(16'h0100, 1'b1, 1'b0, 6);
        nvec++; if (halt !== 1'b1) begin $display("FAIL bnc_first_halt: got %b want 1", halt); nerr++; end
        for (int i = 0; i < 5; i++) begin
            resume = 1'b1; tick(1); resume = 1'b0; tick(2);
        end
        nvec++; if (halt !== 1'b0) begin $display("FAIL bnc_released: got %b want 0", halt); nerr++; end
        access(16'h0200, 1'b1, 1'b0, 4);
        nvec++; if (halt !== 1'b0) begin $display("FAIL bnc_lockout_access: got %b want 0", halt); nerr++; end
        tick(20);
        nvec++; if (halt !== 1'b0) begin $display("FAIL bnc_stay_run: got %b want 0", halt); nerr++; end
        nvec++; if (hits !== 8'd1) begin $display("FAIL bnc_hits1: got %0d want 1", hits); nerr++; end
        access(16'h0300, 1'b1, 1'b0, 6);
        nvec++; if (halt !== 1'b1) begin $display("FAIL bnc_fresh_halt: got %b want 1", halt); nerr++; end
        nvec++; if (hit_addr !== 16'h0300) begin $display("FAIL bnc_addr: got %h want 0300", hit_addr); nerr++; end
        nvec++; if (hits !== 8'd2) begin $display("FAIL bnc_hits2: got %0d want 2", hits); nerr++; end
        pulse_resume();
    endtask

    task automatic test_reset_halted();
        do_reset();
        config_bp(16'h1234, 16'hFFFF, 2'b11, 8'd1, 1'b0);
        access(16'h1234, 1'b1, 1'b0, 6);
        nvec++; if (halt !== 1'b1) begin $display("FAIL rsth_pre_halt: got %b want 1", halt); nerr++; end
        #2 rst_n = 1'b0;
        #1;
        nvec++; if (halt !== 1'b0) begin $display("FAIL rsth_halt: got %b want 0", halt); nerr++; end
        nvec++; if (hits !== 8'd0) begin $display("FAIL rsth_hits: got %0d want 0", hits); nerr++; end
        nvec++; if (hit_addr !== 16'h0000) begin $display("FAIL rsth_addr: got %h want 0000", hit_addr); nerr++; end
        tick(2); rst_n = 1'b1; tick(2);
        access(16'h1234, 1'b0, 1'b1, 6);
        nvec++; if (halt !== 1'b1) begin $display("FAIL rsth_post_halt: got %b want 1", halt); nerr++; end
        nvec++; if (hits !== 8'd1) begin $display("FAIL rsth_post_hits: got %0d want 1", hits); nerr++; end
        nvec++; if (hit_wr !== 1'b1) begin $display("FAIL rsth_post_wr: got %b want 1", hit_wr); nerr++; end
        pulse_resume();
    endtask

    task automatic test_edges();
        do_reset();
        config_bp(16'h4000, 16'hFFFF, 2'b01, 8'd0, 1'b0);
        access(16'h4000, 1'b1, 1'b0, 6);
        nvec++; if (halt !== 1'b1) begin $display("FAIL edge_count0: got %b want 1", halt); nerr++; end
        nvec++; if (hit_wr !== 1'b0) begin $display("FAIL edge_count0_wr: got %b want 0", hit_wr); nerr++; end
        pulse_resume();
        access(16'h4000, 1'b1, 1'b1, 6);
        nvec++; if (halt !== 1'b0) begin $display("FAIL edge_both_low_rdmode: got %b want 0", halt); nerr++; end
        bp_mode = 2'b10;
        access(16'h4000, 1'b1, 1'b1, 6);
        nvec++; if (halt !== 1'b1) begin $display("FAIL edge_both_low_wrmode: got %b want 1", halt); nerr++; end
        nvec++; if (hit_wr !== 1'b1) begin $display("FAIL edge_both_low_wr: got %b want 1", hit_wr); nerr++; end
        pulse_resume();
    endtask

    task automatic test_saturate();
        do_reset();
        config_bp(16'h0000, 16'h0000, 2'b00, 8'd1, 1'b1);
        for (int i = 1; i <= 260; i++) begin
            access(16'(i), 1'b1, 1'b0, 6);
            if (i == 254) begin
                nvec++; if (hits !== 8'hFE) begin $display("FAIL sat_254: got %h want fe", hits); nerr++; end
            end
            if (i == 255) begin
                nvec++; if (hits !== 8'hFF) begin $display("FAIL sat_255: got %h want ff", hits); nerr++; end
            end
            if (i == 260) begin
                nvec++; if (halt !== 1'b1) begin $display("FAIL sat_halt: got %b want 1", halt); nerr++; end
                nvec++; if (hits !== 8'hFF) begin $display("FAIL sat_260: got %h want ff", hits); nerr++; end
                nvec++; if (hit_addr !== 16'd260) begin $display("FAIL sat_addr: got %h want 0104", hit_addr); nerr++; end
            end
            pulse_resume();
        end
    endtask

    initial begin
        tick(1);
        test_reset();
        test_write_bp();
        test_mask_count();
        test_step();
        test_bounce();
        test_reset_halted();
        test_edges();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
